// File: rtl/adrv9001_rx_pack.sv
// adrv9001_rx_pack: strobe-aligned I/Q deserializer packer for the dclk_div domain.
// Finds the 16-bit word boundary from the strobe lane, locks after LOCK_COUNT
// clean word periods and emits {I,Q} (or {Q,I} with SWAP_IQ) as one-cycle
// pulses. Optional framing error counter: define ADRV9001_RX_PACK_ERR_CNT_EN.

// Per-lane byte history and word extraction for a given strobe offset.
module adrv9001_rx_pack_lane #(
    parameter int VEC_W = 8,
    parameter int JW    = $clog2(VEC_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VEC_W-1:0]   din,
    input  logic [JW-1:0]      j,
    output logic [2*VEC_W-1:0] word
);
    localparam int WW = 2 * VEC_W;

    logic [WW-1:0]      hist_q;
    logic [3*VEC_W-1:0] hist;

    // Oldest byte at the top; the current input byte completes the window.
    assign hist = {hist_q, din};
    assign word = WW'(hist >> (VEC_W - int'(j)));

    // Shift the two most recent bytes into the history.
    always_ff @(posedge clk) begin
        if (rst) hist_q <= '0;
        else     hist_q <= hist[WW-1:0];
    end
endmodule

module adrv9001_rx_pack #(
    parameter int LOCK_COUNT = 4,
    parameter bit SWAP_IQ    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  strb_in,
    input  logic [7:0]  i_in,
    input  logic [7:0]  q_in,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        locked,
    output logic [2:0]  align_offset,
    output logic [15:0] err_cnt
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 1;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t     state;
    logic [3:0] run_cnt;
    logic [2:0] rec_j;
    logic       gap;

    logic [3:0] ones;
    logic [2:0] strb_j;
    logic       is_start, is_idle;
    logic [3:0] run_nxt;
    logic       lock_hit, lock_ok, lock_drop, emit;

    // Strobe byte classification: set-bit count and offset of the (last) set bit.
    always_comb begin
        ones   = '0;
        strb_j = '0;
        for (int b = 0; b < VEC_W; b++) begin
            if (strb_in[b]) begin
                ones   = ones + 4'd1;
                strb_j = 3'(7 - b);
            end
        end
    end

    assign is_start = (ones == 4'd1);
    assign is_idle  = (ones == 4'd0);

    // Run continues only on a same-offset start right after an idle gap byte.
    always_comb begin
        run_nxt = 4'd1;
        if (run_cnt != 4'd0 && !gap && strb_j == rec_j) run_nxt = run_cnt + 4'd1;
    end

    assign lock_hit  = (state == SEARCH) && is_start && (run_nxt == 4'(LOCK_COUNT));
    assign lock_ok   = (state == LOCKED) && (gap ? is_idle : (is_start && strb_j == align_offset));
    assign lock_drop = (state == LOCKED) && !lock_ok;
    assign emit      = lock_hit || ((state == LOCKED) && !gap && lock_ok);

    // Alignment FSM. In LOCKED, gap marks the idle byte between two word starts.
    // Leaving LOCKED clears the run so relock needs LOCK_COUNT fresh starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SEARCH;
            run_cnt      <= '0;
            rec_j        <= '0;
            gap          <= 1'b0;
            locked       <= 1'b0;
            align_offset <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (is_start) begin
                        rec_j <= strb_j;
                        gap   <= 1'b1;
                        if (lock_hit) begin
                            state        <= LOCKED;
                            locked       <= 1'b1;
                            align_offset <= strb_j;
                            run_cnt      <= '0;
                        end else begin
                            run_cnt <= run_nxt;
                        end
                    end else begin
                        gap <= 1'b0;
                        if (!(gap && is_idle)) run_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_drop) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        run_cnt <= '0;
                        gap     <= 1'b0;
                    end else begin
                        gap <= ~gap;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    logic [STAGES:0]      vld_pipe;
    logic [STAGES:0][2:0] j_pipe;

    // Carry accepted starts and their offset until the word is fully received.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            j_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], emit};
            j_pipe   <= {j_pipe[STAGES-1:0], strb_j};
        end
    end

    logic [NUM_LANES-1:0][VEC_W-1:0]   lane_in;
    logic [NUM_LANES-1:0][2*VEC_W-1:0] lane_word;

    assign lane_in = {q_in, i_in};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        adrv9001_rx_pack_lane #(.VEC_W(VEC_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .din  (lane_in[g]),
            .j    (j_pipe[STAGES]),
            .word (lane_word[g])
        );
    end

    // Register the packed sample; tdata holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            m_axis_tvalid <= vld_pipe[STAGES];
            if (vld_pipe[STAGES])
                m_axis_tdata <= SWAP_IQ ? {lane_word[1], lane_word[0]} : {lane_word[0], lane_word[1]};
        end
    end

`ifdef ADRV9001_RX_PACK_ERR_CNT_EN
    logic is_ferr;
    assign is_ferr = (ones > 4'd1);

    // Saturating error count; a framing error that also drops lock counts once.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if ((is_ferr || lock_drop) && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_adrv9001_rx_pack.sv
// Randomized bench for adrv9001_rx_pack: builds serial I/Q/strobe bit streams,
// runs them through two instances (SWAP_IQ 0 and 1) and compares every cycle
// against a reference model that works on per-cycle strobe classes and
// absolute bit positions.
module tb_adrv9001_rx_pack;
    localparam int LC   = 4;
    localparam int MAXC = 66600;
    localparam int C_IDLE = 0, C_START = 1, C_FERR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  strb_in, i_in, q_in;
    logic [31:0] tdata, tdata_s;
    logic        tvalid, tvalid_s, locked, locked_s;
    logic [2:0]  align, align_s;
    logic [15:0] err_cnt, err_cnt_s;

    adrv9001_rx_pack #(.LOCK_COUNT(LC), .SWAP_IQ(1'b0)) u_dut (
        .clk(clk), .rst(rst), .strb_in(strb_in), .i_in(i_in), .q_in(q_in),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .locked(locked),
        .align_offset(align), .err_cnt(err_cnt));

    adrv9001_rx_pack #(.LOCK_COUNT(LC), .SWAP_IQ(1'b1)) u_dut_swap (
        .clk(clk), .rst(rst), .strb_in(strb_in), .i_in(i_in), .q_in(q_in),
        .m_axis_tdata(tdata_s), .m_axis_tvalid(tvalid_s), .locked(locked_s),
        .align_offset(align_s), .err_cnt(err_cnt_s));

    always #5 clk = ~clk;

    logic [7:0] sb[MAXC];
    logic [7:0] ib[MAXC];
    logic [7:0] qb[MAXC];
    bit         rstv[MAXC];
    bit         acc[MAXC];
    int         cls[MAXC];
    int         jv[MAXC];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cur;
    int ncyc;

    // Model state
    bit          m_lk;
    int          m_run;
    int          m_lkc;
    logic [2:0]  m_al;
    logic        m_tv;
    logic [31:0] m_td, m_tds;
    int          m_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic put_word(input int p, input logic [15:0] iw, input logic [15:0] qw);
        for (int b = 0; b < 16; b++) begin
            ib[(p + b) / 8][7 - ((p + b) % 8)] = iw[15 - b];
            qb[(p + b) / 8][7 - ((p + b) % 8)] = qw[15 - b];
        end
        sb[p / 8][7 - (p % 8)] = 1'b1;
    endtask

    // n back-to-back words at strobe offset j starting at cycle cur.
    task automatic seg(input int j, input int n, input bit fixed, input logic [15:0] fi, input logic [15:0] fq);
        for (int m = 0; m < n; m++)
            put_word(8 * cur + j + 16 * m,
                     fixed ? fi : 16'($urandom), fixed ? fq : 16'($urandom));
        cur += 2 * n;
    endtask

    function automatic logic [15:0] getw(input bit q, input int c);
        logic [15:0] w;
        int t;
        for (int b = 0; b < 16; b++) begin
            t = 8 * c + jv[c] + b;
            w[15 - b] = q ? qb[t / 8][7 - (t % 8)] : ib[t / 8][7 - (t % 8)];
        end
        return w;
    endfunction

    // Reference behaviour for input cycle k; leaves expected outputs of cycle k+1.
    task automatic model_step(input int k);
        int  cl;
        int  ones;
        bit  drop, ok;
        acc[k] = 1'b0;
        if (rstv[k]) begin
            cls[k] = C_IDLE; jv[k] = 0;
            m_lk = 0; m_run = 0; m_al = '0; m_tv = 0; m_td = '0; m_tds = '0; m_err = 0;
            return;
        end
        ones = $countones(sb[k]);
        cl = (ones == 0) ? C_IDLE : (ones == 1) ? C_START : C_FERR;
        cls[k] = cl;
        jv[k]  = (cl == C_START) ? 7 - $clog2(sb[k]) : 0;
        drop = 0;
        if (m_lk) begin
            if ((k - m_lkc) % 2 == 1) ok = (cl == C_IDLE);
            else                      ok = (cl == C_START) && (jv[k] == int'(m_al));
            if (!ok) begin
                m_lk = 0; m_run = 0; drop = 1;
            end else if ((k - m_lkc) % 2 == 0) begin
                acc[k] = 1'b1;
            end
        end else begin
            if (cl == C_START) begin
                if (m_run > 0 && cls[k-1] == C_IDLE && cls[k-2] == C_START && jv[k-2] == jv[k])
                    m_run++;
                else
                    m_run = 1;
                if (m_run == LC) begin
                    m_lk = 1; m_lkc = k; m_al = 3'(jv[k]); m_run = 0; acc[k] = 1'b1;
                end
            end else if (!(m_run > 0 && cl == C_IDLE && cls[k-1] == C_START)) begin
                m_run = 0;
            end
        end
`ifdef ADRV9001_RX_PACK_ERR_CNT_EN
        if ((cl == C_FERR || drop) && m_err < 65535) m_err++;
`endif
        m_tv = (k >= 2) && acc[k-2] && !rstv[k-1];
        if (m_tv) begin
            m_td  = {getw(0, k - 2), getw(1, k - 2)};
            m_tds = {getw(1, k - 2), getw(0, k - 2)};
        end
    endtask

    initial begin
        int c0, nf, gp;
        for (int c = 0; c < MAXC; c++) begin
            sb[c] = '0; ib[c] = 8'($urandom); qb[c] = 8'($urandom);
            rstv[c] = 0; acc[c] = 0; cls[c] = C_IDLE; jv[c] = 0;
        end
        rstv[0] = 1; rstv[1] = 1; rstv[2] = 1;
        cur = 6;
        seg(0, 12, 1, 16'h1234, 16'hABCD);        // lock at j=0, fixed pattern
        seg(3, 10, 0, '0, '0);                    // offset change, relock at j=3
        seg(5, 8, 1, 16'h8001, 16'h7FFE);         // j=5 fixed pattern
        c0 = cur;
        seg(5, 10, 0, '0, '0);
        sb[c0 + 12] = 8'h81;                      // framing error while locked
        c0 = cur;
        seg(2, 12, 0, '0, '0);
        rstv[c0 + 17] = 1;                        // reset mid-sample while locked
        for (int r = 0; r < 10; r++) begin
            seg(int'($urandom_range(0, 7)), int'($urandom_range(2, 10)), 0, '0, '0);
            gp = int'($urandom_range(0, 3));
            for (int g = 0; g < gp; g++)
                sb[cur + g] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cur += gp;
        end
        cur += 6;
`ifdef ADRV9001_RX_PACK_ERR_CNT_EN
        nf = 65540;
`else
        nf = 20;
`endif
        for (int i = 0; i < nf; i++) sb[cur + i] = 8'h81;
        cur += nf + 4;
        ncyc = cur;

        m_lk = 0; m_run = 0; m_lkc = 0; m_al = '0; m_tv = 0; m_td = '0; m_tds = '0; m_err = 0;
        for (int k = 0; k < ncyc; k++) begin
            rst = rstv[k]; strb_in = sb[k]; i_in = ib[k]; q_in = qb[k];
            @(posedge clk);
            #1;
            cyc = k + 1;
            model_step(k);
            chk("tvalid", {31'd0, tvalid}, {31'd0, m_tv});
            chk("tdata", tdata, m_td);
            chk("tvalid_swap", {31'd0, tvalid_s}, {31'd0, m_tv});
            chk("tdata_swap", tdata_s, m_tds);
            chk("locked", {31'd0, locked}, {31'd0, m_lk});
            chk("align_offset", {29'd0, align}, {29'd0, m_al});
            chk("err_cnt", {16'd0, err_cnt}, 32'(m_err));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
